// File: rtl/arbitro_op.sv
// Round-robin arbiter sharing one operation unit among N request channels.
// Optional watchdog compiled in with `define ARBITRO_TIMEOUT_EN.
module arbitro_op #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 fimOp,
    output logic                 HabOp,
    output logic [$clog2(N)-1:0] sel,
    output logic [N-1:0]         conc,
    output logic                 erro,
    output logic [1:0]           estado
);

    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        OPERA  = 2'd1,
        FIM    = 2'd2,
        INVAL  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] ptr;
    logic [SW-1:0] winner;
    logic [SW-1:0] idx;
    logic          found;
    logic          expire;

    if (N < 2 || N > 8 || TIMEOUT < 2) begin : g_param_check
        $error("arbitro_op: N must be 2..8 and TIMEOUT at least 2");
    end

    // Search starts one past the last winner and wraps, so the last winner ranks lowest.
    // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = SW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef ARBITRO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;
    logic          erro_q;

    assign expire = (cnt == CW'(TIMEOUT - 1));
    assign erro   = erro_q;

    // Counter is held at zero while idle, so every grant starts a fresh window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            erro_q <= 1'b0;
        end else begin
            if (state != OPERA)
                cnt <= '0;
            else if (!fimOp && !expire)
                cnt <= cnt + 1'b1;
            if (state == OPERA && !fimOp && expire)
                erro_q <= 1'b1;
        end
    end
`else
    assign expire = 1'b0;
    assign erro   = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OCIOSO;
            sel   <= '0;
            ptr   <= SW'(N - 1);
        end else begin
            state <= state_nxt;
            if (state == OCIOSO && found)
                sel <= winner;
            if (state == FIM)
                ptr <= sel;
        end
    end

    always_comb begin
        state_nxt = OCIOSO;
        case (state)
            OCIOSO:  state_nxt = found ? OPERA : OCIOSO;
            OPERA:   state_nxt = (fimOp || expire) ? FIM : OPERA;
            FIM:     state_nxt = OCIOSO;
            default: state_nxt = OCIOSO;
        endcase
    end

    always_comb begin
        conc = '0;
        if (state == FIM)
            conc[sel] = 1'b1;
    end

    assign HabOp  = (state == OPERA);
    assign estado = state;

endmodule

// File: tb/tb_arbitro_op.sv
// Directed self-checking bench for arbitro_op (N=4, TIMEOUT=8).
// Watchdog scenarios run when ARBITRO_TIMEOUT_EN is defined; otherwise the endless-wait case runs.
module tb_arbitro_op;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         fimOp;
    logic         HabOp;
    logic [1:0]   sel;
    logic [N-1:0] conc;
    logic         erro;
    logic [1:0]   estado;

    int checks = 0;
    int errors = 0;

    arbitro_op #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .fimOp  (fimOp),
        .HabOp  (HabOp),
        .sel    (sel),
        .conc   (conc),
        .erro   (erro),
        .estado (estado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req   = '0;
        fimOp = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    int       cnt;
    int       order [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] onehot;

    initial begin
        rst   = 1'b0;
        req   = '0;
        fimOp = 1'b0;
        #2;
        check("rst_habop", HabOp, 0);
        check("rst_sel", sel, 0);
        check("rst_conc", conc, 0);
        check("rst_erro", erro, 0);
        check("rst_estado", estado, 0);
        tick();
        rst = 1'b1;

        // All request after reset: channel 0 first; then an async reset mid-grant.
        req = 4'b1111;
        tick();
        check("first_grant_sel", sel, 0);
        check("first_grant_habop", HabOp, 1);
        check("first_grant_estado", estado, 1);
        tick();
        sel_hold_check: check("grant_hold_sel", sel, 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_habop", HabOp, 0);
        check("midrst_sel", sel, 0);
        check("midrst_conc", conc, 0);
        check("midrst_estado", estado, 0);
        check("midrst_erro", erro, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_sel", sel, 0);
        check("post_rst_estado", estado, 1);
        req   = '0;
        fimOp = 1'b1;
        tick();
        check("post_rst_conc", conc, 4'b0001);
        check("post_rst_fim_estado", estado, 2);
        fimOp = 1'b0;
        tick();
        check("post_rst_idle_estado", estado, 0);
        check("post_rst_idle_conc", conc, 0);

        // Single request on channel 2, fimOp on the 5th OPERA cycle.
        req = 4'b0100;
        tick();
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("single_habop_c%0d", c), HabOp, 1);
            check($sformatf("single_estado_c%0d", c), estado, 1);
            check($sformatf("single_sel_c%0d", c), sel, 2);
            check($sformatf("single_conc_c%0d", c), conc, 0);
            if (c == 5) fimOp = 1'b1;
            tick();
        end
        check("single_fim_estado", estado, 2);
        check("single_fim_conc", conc, 4'b0100);
        check("single_fim_habop", HabOp, 0);
        fimOp = 1'b0;
        req   = '0;
        tick();
        check("single_idle_estado", estado, 0);
        check("single_idle_conc", conc, 0);

        // fimOp while idle is ignored.
        fimOp = 1'b1;
        tick();
        check("idle_fimop_estado", estado, 0);
        tick();
        check("idle_fimop_estado2", estado, 0);
        fimOp = 1'b0;

        // Fairness from a fresh reset: order 0,1,2,3,0,1.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("fair_sel_%0d", k), sel, order[k]);
            check($sformatf("fair_habop_%0d", k), HabOp, 1);
            fimOp = 1'b1;
            tick();
            onehot = 4'b0001 << order[k];
            check($sformatf("fair_conc_%0d", k), conc, onehot);
            fimOp = 1'b0;
            req[order[k]] = 1'b0;
            tick();
            check($sformatf("fair_idle_%0d", k), estado, 0);
            req[order[k]] = 1'b1;
        end
        req = '0;
        tick();

        // Ignored inputs: req changes during OPERA, fimOp during FIM.
        do_reset();
        req = 4'b0001;
        tick();
        check("ign_sel0", sel, 0);
        req = 4'b1000;
        tick();
        check("ign_req_sel", sel, 0);
        check("ign_req_estado", estado, 1);
        tick();
        check("ign_req_sel2", sel, 0);
        fimOp = 1'b1;
        tick();
        check("ign_fim_conc", conc, 4'b0001);
        req = '0;
        tick();
        check("ign_fim_estado", estado, 0);
        check("ign_fim_conc_clr", conc, 0);
        check("ign_fim_sel", sel, 0);
        fimOp = 1'b0;

`ifdef ARBITRO_TIMEOUT_EN
        // Watchdog: HabOp high exactly TIMEOUT cycles, then conc and sticky erro.
        do_reset();
        req = 4'b0010;
        tick();
        cnt = 0;
        while (HabOp && cnt < 40) begin
            cnt++;
            tick();
        end
        check("wd_habop_cycles", cnt, TIMEOUT);
        check("wd_conc", conc, 4'b0010);
        check("wd_erro", erro, 1);
        req = '0;
        tick();
        check("wd_idle_erro", erro, 1);
        req = 4'b0001;
        tick();
        check("wd_next_sel", sel, 0);
        fimOp = 1'b1;
        tick();
        check("wd_next_conc", conc, 4'b0001);
        check("wd_next_erro", erro, 1);
        fimOp = 1'b0;
        req   = '0;
        tick();

        // Race: fimOp on the final watchdog cycle wins.
        do_reset();
        req = 4'b0100;
        tick();
        for (int c = 1; c <= TIMEOUT; c++) begin
            check($sformatf("race_habop_c%0d", c), HabOp, 1);
            if (c == TIMEOUT) fimOp = 1'b1;
            tick();
        end
        check("race_estado", estado, 2);
        check("race_conc", conc, 4'b0100);
        check("race_erro", erro, 0);
        fimOp = 1'b0;
        req   = '0;
        tick();
        check("race_idle_erro", erro, 0);
`else
        // Without the watchdog, OPERA waits for fimOp indefinitely.
        do_reset();
        req = 4'b0010;
        tick();
        for (int c = 0; c < 3 * TIMEOUT; c++) tick();
        check("nowd_habop", HabOp, 1);
        check("nowd_sel", sel, 1);
        check("nowd_erro", erro, 0);
        fimOp = 1'b1;
        tick();
        check("nowd_conc", conc, 4'b0010);
        check("nowd_erro_fim", erro, 0);
        fimOp = 1'b0;
        req   = '0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_op.md
# arbitro_op

Round-robin arbiter that shares the single operation unit among N requesting channels. Each channel raises a request once its operands are loaded. The arbiter grants one channel at a time, drives the operation-unit enable and operand-select, and waits for the unit's done flag. It then returns a one-cycle completion pulse to the winner. A watchdog bounds each operation; it can be compiled out.

## Interface
- N, 4: number of requesting channels (2..8)
- TIMEOUT, 255: maximum OPERA cycles per grant (≥2); counter width = $clog2(TIMEOUT)
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 resets)
- req  input  N  per-channel request; level, held until its conc pulse
- fimOp  input  1  operation-unit done; sampled only in OPERA
- HabOp  output  1  operation-unit enable; high exactly in OPERA
- sel  output  $clog2(N)  index of granted channel; stable from grant through FIM
- conc  output  N  one-hot completion pulse, one cycle, in FIM
- erro  output  1  sticky watchdog-expired flag
- estado  output  2  current state code

## Operation
- States:
  - OCIOSO=0:
    - If req != 0, latch winner into sel, clear counter, go to OPERA.
    - Otherwise stay.
  - OPERA=1:
    - HabOp=1.
    - If fimOp=1, go to FIM.
    - Else if counter == TIMEOUT-1, set erro and go to FIM.
    - Else counter+1.
  - FIM=2:
    - conc[sel]=1, HabOp=0, ptr <= sel, go to OCIOSO.
  - Code 3 is unreachable; if ever entered, go to OCIOSO with outputs low.
- Round-robin: the search starts at index (ptr+1) mod N and wraps. The first set req bit wins.
- ptr resets to N-1, so channel 0 has first priority after reset.
- req is sampled only in OCIOSO. Changes in OPERA or FIM are ignored.
- fimOp outside OPERA is ignored.
- fimOp=1 in the same cycle the counter reaches TIMEOUT-1: completion wins and erro is not set.
- erro is sticky: it clears only on reset. Once set, it does not block further grants.
- A requester must drop req on the edge following its conc pulse. A requester that keeps req high re-competes, but at lowest priority.
- HabOp, conc and estado are Moore outputs decoded from the state register. sel is a register.

## Timing
- Reset (rst=0, async): state=OCIOSO, HabOp=0, sel=0, conc=0, erro=0, estado=0, ptr=N-1, counter=0.
- Grant latency: req seen high in OCIOSO at edge k means HabOp=1 and sel valid from edge k+1.
- Release: fimOp=1 in OPERA at edge m means FIM (conc pulse) from m+1, then OCIOSO from m+2.
- Back-to-back grants: the next HabOp rises at m+3 at the earliest. Minimum grant period is 3 cycles (OCIOSO, OPERA, FIM).
- Watchdog: with no fimOp, HabOp stays high exactly TIMEOUT cycles, then FIM.
- Reset mid-operation: all outputs drop asynchronously. A grant in progress is lost and no conc is issued.

## Configuration
- ARBITRO_TIMEOUT_EN
  - Defined: watchdog counter present, behaviour as above.
  - Undefined:
    - No counter logic.
    - OPERA waits indefinitely for fimOp.
    - erro is tied to 0.
    - TIMEOUT is unused.

## Test plan
- Reset: apply rst=0 mid-run → HabOp=0, sel=0, conc=0, erro=0, estado=0 immediately. After release, req=4'b1111 grants channel 0 first.
- Single request: req=4'b0100, fimOp pulsed on the 5th OPERA cycle → HabOp high 5 cycles, sel=2, conc=4'b0100 for one cycle, estado sequence 0,1,…,1,2,0.
- Fairness: all four channels request continuously, each dropping req after conc then re-raising it → grant order 0,1,2,3,0,1.
- Watchdog: TIMEOUT=8, req=4'b0010, fimOp held 0 → HabOp high exactly 8 cycles, then conc=4'b0010 and erro=1. erro stays 1 through the next normal grant.
- Race: TIMEOUT=8, fimOp=1 on the 8th OPERA cycle → FIM entered, erro remains 0.
- Ignored inputs: fimOp=1 while in OCIOSO or FIM, and req changes during OPERA → no state change, sel unchanged.
